// File: rtl/spi_out.sv
// spi_out: mode-0 SPI initiator streaming SRAM words behind a header; define SPI_OUT_CRC_EN for a CRC-16 trailer and crc_error
module spi_out #(
  parameter int ADDRESS_BUS_WIDTH = 14,
  parameter int START_ADDRESS = 0,
  parameter int WORD_COUNT = 16,
  parameter int DEST_ADDRESS = 0,
  parameter int CLOCK_DIV = 2,
  parameter int CS_GAP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start_strobe,
  output logic busy,
  output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
  output logic read_strobe,
  input  logic [15:0] read_data,
  input  logic read_finished_strobe,
  output logic cs,
  output logic sck,
  output logic mosi,
`ifdef SPI_OUT_CRC_EN
  output logic crc_error,
`endif
  input  logic miso
);
  localparam int CW = ADDRESS_BUS_WIDTH + 1;
  localparam logic [15:0] DIV_M1 = 16'(CLOCK_DIV - 1);
  localparam logic [15:0] GAP_M1 = 16'(CS_GAP - 1);
  localparam logic [15:0] DEST = 16'(DEST_ADDRESS);
  localparam logic [ADDRESS_BUS_WIDTH-1:0] START = ADDRESS_BUS_WIDTH'(START_ADDRESS);
  localparam logic [CW-1:0] WORDS = CW'(WORD_COUNT);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, STALL, HOLD, GAP} state_t;
  state_t state_q;
  logic [15:0] cnt_q, sr_q, buf_q;
  logic [3:0] bit_q;
  logic [CW-1:0] words_q, reads_q;
  logic [ADDRESS_BUS_WIDTH-1:0] read_address_q;
  logic busy_q, cs_q, sck_q, read_strobe_q, buf_full_q, tick, last_fall, load;
`ifdef SPI_OUT_CRC_EN
  logic [15:0] crc_q, crc_d, rx_q;
  logic crc_phase_q, crc_error_q;
  assign crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ sr_q[15]) ? 16'h1021 : 16'h0000);
  assign crc_error = crc_error_q;
`else
  logic unused_miso;
  assign unused_miso = miso;
`endif
  assign tick = cnt_q == DIV_M1;
  assign last_fall = state_q == SHIFT && tick && sck_q && bit_q == 4'd15;
  assign load = buf_full_q && (last_fall ? words_q != '0 : state_q == STALL && tick);
  assign busy = busy_q;
  assign read_address = read_address_q;
  assign read_strobe = read_strobe_q;
  assign cs = cs_q;
  assign sck = sck_q;
  assign mosi = sr_q[15];
  // Frame sequencer: SCK divider, shifter, word boundaries and the single-outstanding SRAM prefetch
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      buf_q <= '0;
      bit_q <= '0;
      words_q <= '0;
      reads_q <= '0;
      read_address_q <= START;
      busy_q <= 1'b0;
      cs_q <= 1'b1;
      sck_q <= 1'b0;
      read_strobe_q <= 1'b0;
      buf_full_q <= 1'b0;
`ifdef SPI_OUT_CRC_EN
      crc_q <= '0;
      rx_q <= '0;
      crc_phase_q <= 1'b0;
      crc_error_q <= 1'b0;
`endif
    end else begin
      if (read_strobe_q && read_finished_strobe) begin
        buf_q <= read_data;
        buf_full_q <= 1'b1;
        read_strobe_q <= 1'b0;
        read_address_q <= read_address_q + ADDRESS_BUS_WIDTH'(1);
      end
      case (state_q)
        IDLE: if (start_strobe) begin
          state_q <= SETUP;
          busy_q <= 1'b1;
          cs_q <= 1'b0;
          cnt_q <= '0;
          bit_q <= '0;
          sr_q <= DEST;
          buf_full_q <= 1'b0;
          words_q <= WORDS;
          reads_q <= WORDS - CW'(1);
          read_address_q <= START;
          read_strobe_q <= 1'b1;
`ifdef SPI_OUT_CRC_EN
          crc_q <= 16'hFFFF;
          crc_phase_q <= 1'b0;
          crc_error_q <= 1'b0;
`endif
        end
        SETUP: begin
          cnt_q <= tick ? '0 : cnt_q + 16'd1;
          if (tick) state_q <= SHIFT;
        end
        SHIFT: begin
          cnt_q <= tick ? '0 : cnt_q + 16'd1;
          if (tick) sck_q <= !sck_q;
`ifdef SPI_OUT_CRC_EN
          if (tick && !sck_q && crc_phase_q) rx_q <= {rx_q[14:0], miso};
`endif
          if (tick && sck_q) begin
            bit_q <= bit_q + 4'd1;
            sr_q <= {sr_q[14:0], 1'b0};
`ifdef SPI_OUT_CRC_EN
            if (!crc_phase_q) crc_q <= crc_d;
`endif
          end
          if (last_fall && words_q == '0) begin
`ifdef SPI_OUT_CRC_EN
            if (!crc_phase_q) begin
              sr_q <= crc_d;
              crc_phase_q <= 1'b1;
            end else begin
              state_q <= HOLD;
              crc_error_q <= rx_q != 16'h0000;
            end
`else
            state_q <= HOLD;
`endif
          end else if (last_fall && !buf_full_q) state_q <= STALL;
        end
        STALL: if (buf_full_q) begin
          cnt_q <= tick ? '0 : cnt_q + 16'd1;
          if (tick) state_q <= SHIFT;
        end
        HOLD: begin
          cnt_q <= tick ? '0 : cnt_q + 16'd1;
          if (tick) begin
            cs_q <= 1'b1;
            state_q <= GAP;
          end
        end
        GAP: begin
          cnt_q <= cnt_q == GAP_M1 ? '0 : cnt_q + 16'd1;
          if (cnt_q == GAP_M1) begin
            busy_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (load) begin
        sr_q <= buf_q;
        buf_full_q <= 1'b0;
        words_q <= words_q - CW'(1);
        if (reads_q != '0) begin
          read_strobe_q <= 1'b1;
          reads_q <= reads_q - CW'(1);
        end
      end
    end
endmodule
